// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and lane helpers for the data-memory responder.
// Used by dmem_responder and dmem_array.
package dmem_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   // Reserved size 2'b11 falls through to word handling.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SIZE_B:  lane_mask = 4'b0001 << lo;
         SIZE_H:  lane_mask = lo[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SIZE_B:  lane_data = {4{wdata[7:0]}};
         SIZE_H:  lane_data = {2{wdata[15:0]}};
         default: lane_data = wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic is_unsigned);
      logic [31:0] sh;
      sh = '0;
      case (size)
         SIZE_B: begin
            sh = word >> {lo, 3'b000};
            load_extend = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
         end
         SIZE_H: begin
            sh = word >> {lo[1], 4'b0000};
            load_extend = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
         end
         default: load_extend = word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a load/store master and dmem_responder.
// Handshake: a beat transfers on a rising edge where valid=1 and ready=1; the sender holds
// valid and its payload stable until that edge, and ready may not depend on the next valid.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
                   input  req_ready, resp_valid, resp_rdata, resp_err);
   modport slave  (input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
                   output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables; read data holds between accesses.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one outstanding load/store, access on the edge entering RESP.
// Optional macro DMEM_ERR_EN enables alignment / size / range checking with resp_err.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus,
   output state_t dbg_state
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAST_CNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t          state;
   logic [3:0]      cnt;
   logic            q_write, q_unsigned;
   logic [1:0]      q_size;
   logic [AW+1:0]   q_addr;
   logic [31:0]     q_wdata;
   logic            accept, access, a_write, a_ok, q_ok;
   logic [1:0]      a_size;
   logic [AW+1:0]   a_addr;
   logic [31:0]     a_wdata, ram_rdata;

   assign accept = (state == ST_IDLE) && bus.req_valid;

   // With zero wait states the access happens on the accept edge, so it uses the live request.
   assign a_write = (state == ST_IDLE) ? bus.req_write        : q_write;
   assign a_size  = (state == ST_IDLE) ? bus.req_size         : q_size;
   assign a_addr  = (state == ST_IDLE) ? bus.req_addr[AW+1:0] : q_addr;
   assign a_wdata = (state == ST_IDLE) ? bus.req_wdata        : q_wdata;
   assign access  = reset && ((WAIT_STATES == 0) ? accept : ((state == ST_WAIT) && (cnt == LAST_CNT)));

`ifdef DMEM_ERR_EN
   logic live_err, q_err;

   always_comb begin
      live_err = (bus.req_addr >> (AW + 2)) != 32'd0;
      case (bus.req_size)
         SIZE_B: ;
         SIZE_H: if (bus.req_addr[0]) live_err = 1'b1;
         SIZE_W: if (bus.req_addr[1:0] != 2'b00) live_err = 1'b1;
         default: live_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      q_err <= 1'b0;
      else if (accept) q_err <= live_err;
   end

   assign a_ok         = (state == ST_IDLE) ? ~live_err : ~q_err;
   assign q_ok         = ~q_err;
   assign bus.resp_err = (state == ST_RESP) && q_err;
`else
   assign a_ok         = 1'b1;
   assign q_ok         = 1'b1;
   assign bus.resp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         q_write    <= 1'b0;
         q_unsigned <= 1'b0;
         q_size     <= SIZE_W;
         q_addr     <= '0;
         q_wdata    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (bus.req_valid) begin
               q_write    <= bus.req_write;
               q_unsigned <= bus.req_unsigned;
               q_size     <= bus.req_size;
               q_addr     <= bus.req_addr[AW+1:0];
               q_wdata    <= bus.req_wdata;
               cnt        <= 4'd0;
               state      <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST_CNT) state <= ST_RESP;
            end
            ST_RESP: if (bus.resp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
      .clk   (clk),
      .en    (access),
      .we    (a_write & a_ok),
      .be    (lane_mask(a_size, a_addr[1:0])),
      .addr  (a_addr[AW+1:2]),
      .wdata (lane_data(a_size, a_wdata)),
      .rdata (ram_rdata)
   );

   assign bus.req_ready  = (state == ST_IDLE);
   assign bus.resp_valid = (state == ST_RESP);
   assign bus.resp_rdata = ((state == ST_RESP) && !q_write && q_ok)
                           ? load_extend(ram_rdata, q_size, q_addr[1:0], q_unsigned) : 32'd0;
   assign dbg_state      = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
// Expectations for the DMEM_ERR_EN build are selected by the same macro.
`timescale 1ns/1ps
module tb_dmem_responder;
   import dmem_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   dmem_if b1 ();
   dmem_if b0 ();
   state_t st1, st0;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut (
      .clk(clk), .reset(reset), .bus(b1.slave), .dbg_state(st1));
   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .bus(b0.slave), .dbg_state(st0));

   logic        sel0;
   logic        req_valid, req_write, req_unsigned, resp_ready;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;

   assign b1.req_valid    = req_valid & ~sel0;
   assign b0.req_valid    = req_valid & sel0;
   assign b1.resp_ready   = resp_ready & ~sel0;
   assign b0.resp_ready   = resp_ready & sel0;
   assign b1.req_write    = req_write;
   assign b0.req_write    = req_write;
   assign b1.req_size     = req_size;
   assign b0.req_size     = req_size;
   assign b1.req_unsigned = req_unsigned;
   assign b0.req_unsigned = req_unsigned;
   assign b1.req_addr     = req_addr;
   assign b0.req_addr     = req_addr;
   assign b1.req_wdata    = req_wdata;
   assign b0.req_wdata    = req_wdata;

   logic        o_req_ready, o_resp_valid, o_resp_err;
   logic [31:0] o_resp_rdata;
   assign o_req_ready  = sel0 ? b0.req_ready  : b1.req_ready;
   assign o_resp_valid = sel0 ? b0.resp_valid : b1.resp_valid;
   assign o_resp_err   = sel0 ? b0.resp_err   : b1.resp_err;
   assign o_resp_rdata = sel0 ? b0.resp_rdata : b1.resp_rdata;

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int last_acc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge with the selected DUT idle; returns at a falling edge, DUT idle again.
   task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, input logic exp_err);
      logic [31:0] exp_rd;
      int n, lat;
      exp_rd       = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      n = 0;
      while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
      check("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1 last_acc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!o_resp_valid && lat < 50) begin @(negedge clk); lat++; end
      check("latency", 32'(lat), sel0 ? 32'd1 : 32'd2);
      check("busy_ready", {31'd0, o_req_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, o_resp_valid}, 32'd1);
         check("hold_rdata", o_resp_rdata, exp_rd);
         check("hold_ready", {31'd0, o_req_ready}, 32'd0);
      end
      check("rdata", o_resp_rdata, exp_rd);
      check("err", {31'd0, o_resp_err}, {31'd0, exp_err});
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check("resp_drop", {31'd0, o_resp_valid}, 32'd0);
      check("idle_ready", {31'd0, o_req_ready}, 32'd1);
   endtask

   task automatic tx(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold, input logic exp_err, input logic [31:0] exp_rd);
      exp_q.push_back(exp_rd);
      do_req(wr, sz, uns, addr, wdata, hold, exp_err);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {31'd0, b1.req_ready}, 32'd1);
      check({tag, "_valid"}, {31'd0, b1.resp_valid}, 32'd0);
      check({tag, "_rdata"}, b1.resp_rdata, 32'd0);
      check({tag, "_err"},   {31'd0, b1.resp_err}, 32'd0);
      check({tag, "_state"}, {30'd0, st1}, {30'd0, ST_IDLE});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int a;
      sel0 = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_unsigned = 1'b0; resp_ready = 1'b0;
      req_size = SIZE_W; req_addr = '0; req_wdata = '0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b1;
      @(negedge clk);

      // one wait state: word, byte and half traffic around 0x10
      tx(1, SIZE_W, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
      tx(0, SIZE_W, 0, 32'h10, 32'h0,        0, 0, 32'hDEADBEEF);
      tx(1, SIZE_B, 0, 32'h13, 32'h00000080, 0, 0, 32'h0);
      tx(0, SIZE_B, 0, 32'h13, 32'h0,        0, 0, 32'hFFFFFF80);
      tx(0, SIZE_B, 1, 32'h13, 32'h0,        0, 0, 32'h00000080);
      tx(0, SIZE_W, 0, 32'h10, 32'h0,        0, 0, 32'h80ADBEEF);
      tx(0, SIZE_H, 0, 32'h12, 32'h0,        0, 0, 32'hFFFF80AD);
      tx(0, SIZE_H, 1, 32'h10, 32'h0,        0, 0, 32'h0000BEEF);
      tx(0, SIZE_B, 0, 32'h10, 32'h0,        0, 0, 32'hFFFFFFEF);
      tx(0, SIZE_B, 1, 32'h11, 32'h0,        0, 0, 32'h000000BE);
      tx(1, SIZE_H, 0, 32'h12, 32'h1234A5A5, 0, 0, 32'h0);
      tx(0, SIZE_W, 0, 32'h10, 32'h0,        5, 0, 32'hA5A5BEEF);

      tx(1, SIZE_W, 0, 32'h20, 32'hCAFEF00D, 0, 0, 32'h0);
`ifdef DMEM_ERR_EN
      tx(0, 2'b11,  0, 32'h10,   32'h0,      0, 1, 32'h0);
      tx(0, SIZE_W, 0, 32'h1010, 32'h0,      0, 1, 32'h0);
      tx(0, SIZE_W, 0, 32'h12,   32'h0,      0, 1, 32'h0);
      tx(1, SIZE_H, 0, 32'h21,   32'h0000FFFF, 0, 1, 32'h0);
      tx(0, SIZE_W, 0, 32'h20,   32'h0,      0, 0, 32'hCAFEF00D);
`else
      tx(0, 2'b11,  0, 32'h10,   32'h0,      0, 0, 32'hA5A5BEEF);
      tx(0, SIZE_W, 0, 32'h1010, 32'h0,      0, 0, 32'hA5A5BEEF);
      tx(0, SIZE_W, 0, 32'h12,   32'h0,      0, 0, 32'hA5A5BEEF);
      tx(1, SIZE_H, 0, 32'h21,   32'h0000FFFF, 0, 0, 32'h0);
      tx(0, SIZE_W, 0, 32'h20,   32'h0,      0, 0, 32'hCAFEFFFF);
`endif

      // reset in the middle of a store's wait state must drop the store
      tx(1, SIZE_W, 0, 32'h40, 32'h11223344, 0, 0, 32'h0);
      req_write = 1'b1; req_size = SIZE_W; req_addr = 32'h40; req_wdata = 32'hAAAAAAAA;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_wait_state", {30'd0, st1}, {30'd0, ST_WAIT});
      reset = 1'b0;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tx(0, SIZE_W, 0, 32'h40, 32'h0, 0, 0, 32'h11223344);

      // zero wait states: back-to-back loads at one per two cycles
      sel0 = 1'b1;
      @(negedge clk);
      tx(1, SIZE_W, 0, 32'h0, 32'h01020304, 0, 0, 32'h0);
      tx(1, SIZE_W, 0, 32'h4, 32'h55667788, 0, 0, 32'h0);
      tx(0, SIZE_W, 0, 32'h0, 32'h0, 0, 0, 32'h01020304);
      a = last_acc;
      tx(0, SIZE_W, 0, 32'h4, 32'h0, 0, 0, 32'h55667788);
      check("b2b_interval1", 32'(last_acc - a), 32'd2);
      a = last_acc;
      tx(0, SIZE_B, 1, 32'h1, 32'h0, 0, 0, 32'h00000003);
      check("b2b_interval2", 32'(last_acc - a), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage size in 32-bit words (power of two, >=16).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between acceptance and access (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have ports req_valid input 1 and req_ready output 1, forming the request handshake.
REQ-006 SHALL have port req_write  input  1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2: 00 byte, 01 half, 10 word; 11 reserved.
REQ-008 SHALL have port req_unsigned  input  1: load zero-extends when 1 and sign-extends when 0.
REQ-009 SHALL have ports req_addr input 32 (byte address) and req_wdata input 32 (store data, LSB-justified).
REQ-010 SHALL have ports resp_valid output 1 and resp_ready input 1, forming the response handshake.
REQ-011 SHALL have ports resp_rdata output 32 (load result) and resp_err output 1 (request rejected).

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-013 SHALL accept a request on an edge with req_valid=1 in IDLE, and SHALL latch write, size, unsigned, addr and wdata at that edge.
REQ-014 SHALL go IDLE->WAIT on acceptance when WAIT_STATES>0, count WAIT_STATES cycles, then WAIT->RESP.
REQ-015 SHALL go IDLE->RESP directly on acceptance when WAIT_STATES=0.
REQ-016 SHALL perform the array access on the edge entering RESP, so resp_valid rises exactly WAIT_STATES+1 cycles after acceptance.
REQ-017 SHALL write stores with byte enables: byte writes lane addr[1:0], half writes lanes {addr[1],0} and {addr[1],1}, word writes all lanes; other bytes SHALL be unchanged.
REQ-018 SHALL return loads by shifting the selected lanes to bit 0 and then sign- or zero-extending; resp_rdata SHALL be 0 for stores and for errored requests.
REQ-019 SHALL index words with addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored when DMEM_ERR_EN is undefined.
REQ-020 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-021 SHALL not accept a new request on the RESP->IDLE edge, allowing at most one outstanding transaction.
REQ-022 SHALL treat req_size=11 as word when DMEM_ERR_EN is undefined.

Reset
REQ-023 SHALL, while reset=0, force state IDLE, clear the wait counter, and set req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-024 SHALL abandon any transaction in flight on reset; a store whose access edge did not occur SHALL leave memory unchanged.
REQ-025 SHALL not clear array contents on reset.

Configuration
REQ-026 SHALL honour macro DMEM_ERR_EN.
- When defined: misalignment (half with addr[0]=1, word with addr[1:0]!=0), req_size=11, or addr >= 4*DEPTH_WORDS SHALL give resp_err=1 with unchanged latency and no memory write.
- When undefined: resp_err SHALL be tied 0 and no checking logic SHALL exist.

Structure
REQ-027 SHALL place the size encodings (SIZE_B, SIZE_H, SIZE_W) and the FSM state typedef in shared package dmem_pkg.
REQ-028 SHALL place storage in sub-module dmem_array: a synchronous byte-enabled word RAM with one read/write port.

Verification
REQ-029 With WAIT_STATES=1, store word 0xDEADBEEF at 0x10, then load word at 0x10 -> resp_rdata=0xDEADBEEF, resp_valid 2 cycles after each accept.
REQ-030 Store byte 0x80 at 0x13, then load signed byte at 0x13 -> 0xFFFFFF80; load unsigned byte -> 0x00000080; load word 0x10 -> 0x80ADBEEF.
REQ-031 Hold resp_ready=0 for 5 cycles during a load -> resp_valid and resp_rdata stable, req_ready=0 throughout, with a single response.
REQ-032 With DMEM_ERR_EN defined, store half at 0x21 -> resp_err=1, resp_rdata=0, and a following word load at 0x20 returns the prior value.
REQ-033 Assert reset=0 mid-WAIT of a store to 0x40 -> outputs return to reset values immediately, and a later load of 0x40 shows the old data.
REQ-034 With WAIT_STATES=0, run back-to-back loads with resp_ready=1 -> resp_valid 1 cycle after accept, one transaction every 2 cycles.
